// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef logic [31:0] word;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
// ============================================================================
// Module      : word_assembler
// Description : Collects four stream bytes into a little-endian word.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module word_assembler
    import loader_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output word        word_out,
    output logic       word_ready
);

    logic [1:0]  lane;
    logic [23:0] shift;

    // Only three bytes are stored; the fourth is merged combinationally so
    // the word is available in the same cycle its last byte arrives.
    always_ff @(posedge clock) begin
        if (clear) begin
            lane  <= 2'd0;
            shift <= 24'd0;
        end else if (byte_valid) begin
            lane  <= lane + 2'd1;
            shift <= {byte_in, shift[23:8]};
        end
    end

    assign word_out   = {byte_in, shift};
    assign word_ready = byte_valid && (lane == 2'd3);

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Writes a length-prefixed, XOR-checksummed byte image into
//               instruction memory and then releases the core from reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output word         wr_data,
    output logic        hold_cpu,
    output logic        done,
    output logic        error
);

    loader_state_t       state, state_next;
    logic [15:0]         len;
    logic [DEPTH_LOG2:0] index;
    logic [7:0]          xor_acc;
    logic                xfer;
    logic                asm_clear;
    logic                asm_valid;
    logic                word_ready;
    word                 word_out;

    assign xfer      = in_valid && in_ready;
    assign asm_clear = reset || (state == LEN1);
    assign asm_valid = xfer && (state == DATA);

    word_assembler u_assembler (
        .clock      (clock),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (in_data),
        .word_out   (word_out),
        .word_ready (word_ready)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            LEN0: begin
                in_ready = 1'b1;
                if (xfer) state_next = LEN1;
            end
            LEN1: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (32'({in_data, len[7:0]}) > (32'd1 << DEPTH_LOG2))
                        state_next = ERR;
                    else if ({in_data, len[7:0]} == 16'd0)
                        state_next = CSUM;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_ready && (32'(index) + 32'd1 == 32'(len)))
                    state_next = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (xfer) state_next = (in_data == xor_acc) ? DONE : ERR;
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= LEN0;
            len     <= 16'd0;
            index   <= '0;
            xor_acc <= 8'd0;
            wr_en   <= 1'b0;
            wr_addr <= BASE_ADDR;
            wr_data <= '0;
        end else begin
            state <= state_next;
            wr_en <= word_ready;
            // The checksum byte itself is never folded into the running XOR.
            if (xfer && (state != CSUM)) xor_acc <= xor_acc ^ in_data;
            if (xfer && (state == LEN0)) len[7:0]  <= in_data;
            if (xfer && (state == LEN1)) len[15:8] <= in_data;
            if (word_ready) begin
                wr_addr <= BASE_ADDR + 32'(BYTES_PER_WORD) * 32'(index);
                wr_data <= word_out;
                index   <= index + 1'b1;
            end
        end
    end

    assign hold_cpu = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Drives one byte stream into three loader configurations and
//               checks each against an image-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int ST_RUN  = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready [3];
    logic        wr_en    [3];
    logic [31:0] wr_addr  [3];
    logic [31:0] wr_data  [3];
    logic        hold_cpu [3];
    logic        done     [3];
    logic        error    [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  acc [3][64];
    int          cnt [3];
    logic [31:0] last_addr [3];
    logic [31:0] last_data [3];
    bit          exp_wr [3];
    logic [7:0]  s [64];
    int          slen;

    always #5 clock = ~clock;

    program_loader #(.BASE_ADDR(32'h0), .DEPTH_LOG2(10)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .hold_cpu(hold_cpu[0]), .done(done[0]), .error(error[0]));

    program_loader #(.BASE_ADDR(32'h100), .DEPTH_LOG2(10)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .hold_cpu(hold_cpu[1]), .done(done[1]), .error(error[1]));

    program_loader #(.BASE_ADDR(32'h0), .DEPTH_LOG2(2)) u_dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
        .wr_data(wr_data[2]), .hold_cpu(hold_cpu[2]), .done(done[2]), .error(error[2]));

    function automatic logic [31:0] base_of(int i);
        return (i == 1) ? 32'h100 : 32'h0;
    endfunction

    function automatic int cap_of(int i);
        return (i == 2) ? 4 : 1024;
    endfunction

    function automatic int len_of(int i);
        return int'({acc[i][1], acc[i][0]});
    endfunction

    // Status of an image judged only from the bytes a loader has accepted.
    function automatic int model_status(int i);
        int n;
        logic [7:0] x;
        if (cnt[i] < 2) return ST_RUN;
        n = len_of(i);
        if (n > cap_of(i)) return ST_ERR;
        if (cnt[i] < 2 + 4 * n + 1) return ST_RUN;
        x = 8'd0;
        for (int k = 0; k < 2 + 4 * n; k++) x = x ^ acc[i][k];
        return (x == acc[i][2 + 4 * n]) ? ST_DONE : ST_ERR;
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int st;
        for (int i = 0; i < 3; i++) begin
            st = model_status(i);
            chk("wr_en",    i, 32'(wr_en[i]),    32'(exp_wr[i]));
            chk("wr_addr",  i, wr_addr[i],       last_addr[i]);
            chk("wr_data",  i, wr_data[i],       last_data[i]);
            chk("in_ready", i, 32'(in_ready[i]), 32'(st == ST_RUN));
            chk("done",     i, 32'(done[i]),     32'(st == ST_DONE));
            chk("error",    i, 32'(error[i]),    32'(st == ST_ERR));
            chk("hold_cpu", i, 32'(hold_cpu[i]), 32'(st != ST_DONE));
        end
    endtask

    task automatic step(bit v, logic [7:0] d);
        int j;
        in_valid = v;
        in_data  = d;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            exp_wr[i] = 1'b0;
            if (v && model_status(i) == ST_RUN) begin
                acc[i][cnt[i]] = d;
                cnt[i]++;
                j = cnt[i] - 3;
                if (cnt[i] >= 3 && j < 4 * len_of(i) && (j % 4) == 3) begin
                    exp_wr[i]    = 1'b1;
                    last_addr[i] = base_of(i) + 32'(4 * (j / 4));
                    last_data[i] = {acc[i][cnt[i]-1], acc[i][cnt[i]-2],
                                    acc[i][cnt[i]-3], acc[i][cnt[i]-4]};
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt[i]       = 0;
            exp_wr[i]    = 1'b0;
            last_addr[i] = base_of(i);
            last_data[i] = 32'h0;
        end
        check_outputs();
    endtask

    task automatic push(logic [7:0] b);
        s[slen] = b;
        slen++;
    endtask

    task automatic build_image(int n, bit bad);
        logic [7:0] x;
        logic [7:0] b;
        slen = 0;
        push(8'(n));
        push(8'(n >> 8));
        x = s[0] ^ s[1];
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            push(b);
            x = x ^ b;
        end
        if (bad) x = x ^ (8'd1 << $urandom_range(0, 7));
        push(x);
    endtask

    task automatic run_stream(int gapmax);
        for (int p = 0; p < slen; p++) begin
            repeat ($urandom_range(0, gapmax)) step(1'b0, 8'($urandom));
            step(1'b1, s[p]);
        end
        repeat (3) step(1'b0, 8'h00);
    endtask

    task automatic image_two_words(logic [7:0] cs);
        slen = 0;
        push(8'h02); push(8'h00);
        push(8'h13); push(8'h00); push(8'h00); push(8'h00);
        push(8'h6F); push(8'h00); push(8'h00); push(8'h00);
        push(cs);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clock);
        do_reset();

        image_two_words(8'h7E);
        run_stream(0);
        do_reset();

        slen = 0;
        push(8'h00); push(8'h00); push(8'h00);
        run_stream(0);
        do_reset();

        image_two_words(8'h7F);
        run_stream(0);
        do_reset();

        build_image(5, 1'b0);
        run_stream(0);
        do_reset();

        image_two_words(8'h7E);
        run_stream(5);
        do_reset();

        slen = 0;
        push(8'h02); push(8'h00); push(8'h13); push(8'h00); push(8'h00);
        run_stream(0);
        do_reset();
        slen = 0;
        push(8'h01); push(8'h00);
        push(8'h93); push(8'h00); push(8'h50); push(8'h00);
        push(8'hC2);
        run_stream(0);
        do_reset();

        for (int r = 0; r < 10; r++) begin
            build_image($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            run_stream(3);
            do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
